// File: rtl/snes_pad_reader.sv
// Console-side SNES/NES pad reader: drives latch and clock, samples serial data,
// and publishes a 16-bit active-low button word plus a presence flag.
module snes_pad_reader #(
    parameter int unsigned HALF_CYC = 128,
    parameter int unsigned POLL_CYC = 357955
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        poll_en,
    output logic        pad_latch,
    output logic        pad_clk,
    input  logic        pad_data,
    output logic [15:0] buttons,
    output logic        present,
    output logic        valid
);

    localparam int unsigned CNT_W = $clog2(2 * HALF_CYC);
    localparam int unsigned TMR_W = $clog2(POLL_CYC);
    localparam int unsigned BIT_W = 5;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(16);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_GAP,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [TMR_W-1:0]   timer;
    logic [BIT_W-1:0]   bit_cnt;
    logic [16:0]        shift;
    logic               data_meta;
    logic               data_s;
    logic               start_c;
    logic               cnt_last_c;
    logic               latch_nxt;
    logic               clk_nxt;
    logic               valid_nxt;
    logic               load_nxt;

    // Timer sits at 0 while disabled, so the first enabled cycle is also a start.
    assign start_c    = poll_en && (timer == '0);
    assign cnt_last_c = (state == S_LATCH) ? (cnt == LATCH_LAST) : (cnt == HALF_LAST);

    // Frame period timer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (!poll_en || timer == TMR_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Two-flop synchroniser; idles at the pulled-up level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_meta <= 1'b1;
            data_s    <= 1'b1;
        end else begin
            data_meta <= pad_data;
            data_s    <= data_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_c)    state_nxt = S_LATCH;
            S_LATCH: if (cnt_last_c) state_nxt = S_GAP;
            S_GAP:   if (cnt_last_c) state_nxt = S_LOW;
            S_LOW:   if (cnt_last_c) state_nxt = S_HIGH;
            S_HIGH:  if (cnt_last_c) state_nxt = (bit_cnt == LAST_BIT) ? S_DONE : S_LOW;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Phase counter, bit index and sample shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '1;
        end else begin
            if (state == S_IDLE || state_nxt != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == S_IDLE) begin
                bit_cnt <= '0;
            end else if (state == S_HIGH && cnt_last_c) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (state == S_LOW && cnt_last_c) begin
                shift[bit_cnt] <= data_s;
            end
        end
    end

    // Output decode from the next state so registered outputs line up with the state.
    always_comb begin
        latch_nxt = 1'b0;
        clk_nxt   = 1'b1;
        valid_nxt = 1'b0;
        load_nxt  = 1'b0;
        case (state_nxt)
            S_LATCH: latch_nxt = 1'b1;
            S_LOW:   clk_nxt   = 1'b0;
            S_DONE: begin
                valid_nxt = 1'b1;
                load_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers; the result word is loaded whole, only on DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
            valid     <= 1'b0;
            buttons   <= 16'hFFFF;
            present   <= 1'b0;
        end else begin
            pad_latch <= latch_nxt;
            pad_clk   <= clk_nxt;
            valid     <= valid_nxt;
            if (load_nxt) begin
                buttons <= shift[15:0];
                present <= ~shift[16];
            end
        end
    end

endmodule
